// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Widest operand the magnitude helper handles.
   localparam int unsigned MaxWidth = 64;

   // Magnitude of a zero-extended two's-complement value whose sign bit is neg.
   // The caller truncates the result back to its own width.
   function automatic logic [MaxWidth-1:0] abs_val(input logic [MaxWidth-1:0] value,
                                                   input logic                neg);
      return neg ? -value : value;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the ALU wrapper (master) and the divider (slave).
interface seq_divider_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             divide_by_zero;
   logic             overflow;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, divide_by_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, divide_by_zero, overflow
   );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, select.
module div_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quo_out
);
   // One extra bit above the partial remainder carries the trial borrow.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic             borrow;

   // Shift, subtract, keep the difference only when it did not go negative.
   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      trial   = shifted - {2'b00, divisor};
      borrow  = trial[WIDTH+1];
      rem_out = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], ~borrow};
   end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake, optional signed mode.
// WIDTH must lie between 2 and div_pkg::MaxWidth.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned SIGNED = 0
) (
   input logic          clk,
   input logic          rst,
   seq_divider_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   div_state_t       state_q, state_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [WIDTH:0]   rem_q, rem_d;        // partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;        // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvsr_q, dvsr_d;      // divisor magnitude
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_out_q, dbz_out_d;
   logic             ovf_out_q, ovf_out_d;

   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH:0]   rem_step;
   logic [WIDTH-1:0] quo_step;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic             ovf_fix;

   // Operand signs and magnitudes; unsigned mode never negates.
   always_comb begin
      dvd_neg = (SIGNED != 0) && bus.dividend[WIDTH-1];
      dvs_neg = (SIGNED != 0) && bus.divisor[WIDTH-1];
      dvd_mag = WIDTH'(abs_val(MaxWidth'(bus.dividend), dvd_neg));
      dvs_mag = WIDTH'(abs_val(MaxWidth'(bus.divisor), dvs_neg));
   end

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_in (rem_q),
      .quo_in (quo_q),
      .divisor(dvsr_q),
      .rem_out(rem_step),
      .quo_out(quo_step)
   );

   // Sign fix-up of the finished magnitudes. A positive quotient with its top bit set can
   // only come from MIN / -1, so the datapath itself flags signed overflow.
   always_comb begin
      quo_fix = q_neg_q ? -quo_q : quo_q;
      rem_fix = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      ovf_fix = (SIGNED != 0) && !dbz_q && !q_neg_q && quo_q[WIDTH-1];
   end

   // Next-state logic for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvsr_d      = dvsr_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      dbz_d       = dbz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_out_d   = dbz_out_q;
      ovf_out_d   = ovf_out_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  // Skip the iterations: quotient 0, remainder is the raw dividend.
                  quo_d   = '0;
                  rem_d   = {1'b0, bus.dividend};
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  quo_d   = dvd_mag;
                  dvsr_d  = dvs_mag;
                  rem_d   = '0;
                  count_d = '0;
                  q_neg_d = dvd_neg ^ dvs_neg;
                  r_neg_d = dvd_neg;
                  dbz_d   = 1'b0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            rem_d   = rem_step;
            quo_d   = quo_step;
            count_d = count_q + CntW'(1);
            if (count_q == CntW'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            quotient_d  = quo_fix;
            remainder_d = rem_fix;
            dbz_out_d   = dbz_q;
            ovf_out_d   = ovf_fix;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any division in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         dbz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_out_q   <= 1'b0;
         ovf_out_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvsr_q      <= dvsr_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         dbz_q       <= dbz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_out_q   <= dbz_out_d;
         ovf_out_q   <= ovf_out_d;
      end
   end

   // Results become visible in the DONE cycle and are held afterwards.
   always_comb begin
      bus.busy           = (state_q == RUN);
      bus.done           = (state_q == DONE);
      bus.quotient       = (state_q == DONE) ? quo_fix : quotient_q;
      bus.remainder      = (state_q == DONE) ? rem_fix : remainder_q;
      bus.divide_by_zero = (state_q == DONE) ? dbz_q : dbz_out_q;
      bus.overflow       = (state_q == DONE) ? ovf_fix : ovf_out_q;
   end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: an unsigned and a signed instance share one stimulus stream.
module tb_seq_divider;
   localparam int unsigned W = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   int          total = 0;
   int          bad   = 0;

   seq_divider_if #(.WIDTH(W)) bus_u ();
   seq_divider_if #(.WIDTH(W)) bus_s ();

   assign bus_u.start    = start;
   assign bus_u.dividend = dividend;
   assign bus_u.divisor  = divisor;
   assign bus_s.start    = start;
   assign bus_s.dividend = dividend;
   assign bus_s.divisor  = divisor;

   seq_divider #(.WIDTH(W), .SIGNED(0)) u_dut_u (.clk(clk), .rst(rst), .bus(bus_u));
   seq_divider #(.WIDTH(W), .SIGNED(1)) u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));

   always #5 clk = ~clk;

   // {done, quotient, remainder, divide_by_zero, overflow}
   logic [34:0] obs_u, obs_s;
   assign obs_u = {bus_u.done, bus_u.quotient, bus_u.remainder, bus_u.divide_by_zero,
                   bus_u.overflow};
   assign obs_s = {bus_s.done, bus_s.quotient, bus_s.remainder, bus_s.divide_by_zero,
                   bus_s.overflow};

   // Reference: plain integer division, truncating toward zero in signed mode.
   function automatic logic [33:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input bit sgn);
      logic [15:0] q, r;
      logic        dz, ov;
      int          sa, sb;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 16'd0) begin
         q  = 16'd0;
         r  = a;
         dz = 1'b1;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         q  = 16'(sa / sb);
         r  = 16'(sa % sb);
         ov = ((sa / sb) > 32767);
      end
      return {q, r, dz, ov};
   endfunction

   // Issue one division from a negedge with the DUT idle; returns at the negedge where done
   // is seen (or after a bounded wait). lat counts edges from the sampling edge inclusive.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                        output int busy_cyc);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      lat      = 1;
      busy_cyc = 0;
      @(negedge clk);
      start = 1'b0;
      while (bus_u.done !== 1'b1 && lat < 40) begin
         if (bus_u.busy === 1'b1) busy_cyc++;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++;
      if ({bus_u.busy, obs_u} !== 36'd0) begin
         bad++;
         $display("FAIL reset_u: got %h want 0", {bus_u.busy, obs_u});
      end
      total++;
      if ({bus_s.busy, obs_s} !== 36'd0) begin
         bad++;
         $display("FAIL reset_s: got %h want 0", {bus_s.busy, obs_s});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus_u.busy, obs_u, bus_s.busy, obs_s} !== 72'd0) begin
         bad++;
         $display("FAIL reset_idle: got %h want 0", {bus_u.busy, obs_u, bus_s.busy, obs_s});
      end
   endtask

   task automatic test_basic;
      int lat, bc;
      do_op(16'd1000, 16'd7, lat, bc);
      total++;
      if (lat != 17) begin
         bad++;
         $display("FAIL basic_latency: got %0d want 17", lat);
      end
      total++;
      if (bc != 16) begin
         bad++;
         $display("FAIL basic_busy: got %0d want 16", bc);
      end
      total++;
      if (obs_u !== {1'b1, 16'd142, 16'd6, 2'b00}) begin
         bad++;
         $display("FAIL basic_u: got %h want %h", obs_u, {1'b1, 16'd142, 16'd6, 2'b00});
      end
      total++;
      if (obs_s !== {1'b1, model(16'd1000, 16'd7, 1'b1)}) begin
         bad++;
         $display("FAIL basic_s: got %h want %h", obs_s, {1'b1, model(16'd1000, 16'd7, 1'b1)});
      end
      @(negedge clk);
      total++;
      if ({bus_u.busy, obs_u} !== {1'b0, 1'b0, 16'd142, 16'd6, 2'b00}) begin
         bad++;
         $display("FAIL basic_hold: got %h want %h", {bus_u.busy, obs_u},
                  {1'b0, 1'b0, 16'd142, 16'd6, 2'b00});
      end
   endtask

   task automatic test_signed;
      logic [15:0] sa [3];
      logic [15:0] sb [3];
      logic [33:0] want [3];
      int          lat, bc;
      sa[0] = 16'hFFF9; sb[0] = 16'd2;    want[0] = {16'hFFFD, 16'hFFFF, 2'b00};
      sa[1] = 16'd7;    sb[1] = 16'hFFFE; want[1] = {16'hFFFD, 16'd1, 2'b00};
      sa[2] = 16'h8000; sb[2] = 16'hFFFF; want[2] = {16'h8000, 16'd0, 2'b01};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         do_op(sa[i], sb[i], lat, bc);
         total++;
         if (obs_s !== {1'b1, want[i]}) begin
            bad++;
            $display("FAIL signed_s[%0d]: got %h want %h", i, obs_s, {1'b1, want[i]});
         end
         total++;
         if (obs_u !== {1'b1, model(sa[i], sb[i], 1'b0)}) begin
            bad++;
            $display("FAIL signed_u[%0d]: got %h want %h", i, obs_u,
                     {1'b1, model(sa[i], sb[i], 1'b0)});
         end
      end
   endtask

   task automatic test_div_zero;
      int lat, bc;
      @(negedge clk);
      do_op(16'h1234, 16'd0, lat, bc);
      total++;
      if (lat != 1 || bc != 0) begin
         bad++;
         $display("FAIL dbz_timing: got lat=%0d busy=%0d want lat=1 busy=0", lat, bc);
      end
      total++;
      if (obs_u !== {1'b1, 16'd0, 16'h1234, 2'b10} || obs_s !== {1'b1, 16'd0, 16'h1234, 2'b10})
      begin
         bad++;
         $display("FAIL dbz_result: got %h / %h want %h", obs_u, obs_s,
                  {1'b1, 16'd0, 16'h1234, 2'b10});
      end
      @(negedge clk);
      do_op(16'd0, 16'd5, lat, bc);
      total++;
      if (lat != 17 || obs_u !== {1'b1, 34'd0} || obs_s !== {1'b1, 34'd0}) begin
         bad++;
         $display("FAIL zero_dividend: got lat=%0d %h / %h want lat=17 %h", lat, obs_u, obs_s,
                  {1'b1, 34'd0});
      end
   endtask

   task automatic test_ignore_start;
      int n;
      @(negedge clk);
      dividend = 16'd50000;
      divisor  = 16'd123;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      dividend = 16'd9;
      divisor  = 16'd3;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (bus_u.done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n != 10) begin
         bad++;
         $display("FAIL ignore_timing: got %0d want 10", n);
      end
      total++;
      if (obs_u !== {1'b1, model(16'd50000, 16'd123, 1'b0)}) begin
         bad++;
         $display("FAIL ignore_u: got %h want %h", obs_u,
                  {1'b1, model(16'd50000, 16'd123, 1'b0)});
      end
      total++;
      if (obs_s !== {1'b1, model(16'd50000, 16'd123, 1'b1)}) begin
         bad++;
         $display("FAIL ignore_s: got %h want %h", obs_s,
                  {1'b1, model(16'd50000, 16'd123, 1'b1)});
      end
      // start raised during the DONE cycle must not be taken.
      dividend = 16'd20;
      divisor  = 16'd4;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({bus_u.busy, bus_u.done, bus_s.busy, bus_s.done} !== 4'b0000) begin
            bad++;
            $display("FAIL done_start[%0d]: got %b want 0000", k,
                     {bus_u.busy, bus_u.done, bus_s.busy, bus_s.done});
         end
         @(negedge clk);
      end
      total++;
      if (obs_u !== {1'b0, model(16'd50000, 16'd123, 1'b0)}) begin
         bad++;
         $display("FAIL ignore_hold: got %h want %h", obs_u,
                  {1'b0, model(16'd50000, 16'd123, 1'b0)});
      end
   endtask

   task automatic test_reset_mid_run;
      int lat, bc;
      bit seen_done;
      @(negedge clk);
      dividend = 16'd40000;
      divisor  = 16'd3;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({bus_u.busy, obs_u, bus_s.busy, obs_s} !== 72'd0) begin
         bad++;
         $display("FAIL midrun_reset: got %h want 0", {bus_u.busy, obs_u, bus_s.busy, obs_s});
      end
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus_u.done === 1'b1 || bus_s.done === 1'b1) seen_done = 1'b1;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus_u.done === 1'b1 || bus_s.done === 1'b1 || bus_u.busy === 1'b1) seen_done = 1'b1;
      end
      total++;
      if (seen_done) begin
         bad++;
         $display("FAIL midrun_no_done: got activity after abort, want none");
      end
      do_op(16'd65535, 16'd255, lat, bc);
      total++;
      if (lat != 17 || obs_u !== {1'b1, 16'd257, 16'd0, 2'b00}) begin
         bad++;
         $display("FAIL after_reset_u: got lat=%0d %h want lat=17 %h", lat, obs_u,
                  {1'b1, 16'd257, 16'd0, 2'b00});
      end
      total++;
      if (obs_s !== {1'b1, model(16'd65535, 16'd255, 1'b1)}) begin
         bad++;
         $display("FAIL after_reset_s: got %h want %h", obs_s,
                  {1'b1, model(16'd65535, 16'd255, 1'b1)});
      end
   endtask

   // Random operands issued back to back: each start lands in the first IDLE cycle.
   task automatic test_back_to_back;
      logic [15:0] a, b;
      int          lat, bc, kind, want_lat;
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         a    = 16'($urandom);
         b    = 16'($urandom);
         if (kind == 0) b = 16'd0;
         else if (kind == 1) begin
            a = 16'h8000;
            b = 16'hFFFF;
         end else if (kind == 2) b = 16'($urandom_range(1, 15));
         else if (kind == 3) b = 16'hFFFF;
         else if (kind == 4) a = 16'($urandom_range(0, 3));
         @(negedge clk);
         do_op(a, b, lat, bc);
         want_lat = (b == 16'd0) ? 1 : 17;
         total++;
         if (lat != want_lat) begin
            bad++;
            $display("FAIL rand_lat[%0d]: got %0d want %0d (a=%h b=%h)", i, lat, want_lat, a, b);
         end
         total++;
         if (obs_u !== {1'b1, model(a, b, 1'b0)}) begin
            bad++;
            $display("FAIL rand_u[%0d]: got %h want %h (a=%h b=%h)", i, obs_u,
                     {1'b1, model(a, b, 1'b0)}, a, b);
         end
         total++;
         if (obs_s !== {1'b1, model(a, b, 1'b1)}) begin
            bad++;
            $display("FAIL rand_s[%0d]: got %h want %h (a=%h b=%h)", i, obs_s,
                     {1'b1, model(a, b, 1'b1)}, a, b);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 16'd0;
      divisor  = 16'd0;
      test_reset;
      test_basic;
      test_signed;
      test_div_zero;
      test_ignore_start;
      test_reset_mid_run;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
